// File: rtl/bsg_dlatch_drain_mem.sv
// rtl/bsg_dlatch_drain_mem.sv - two-entry resettable storage for the latch drain queue
//
// Ports:
//   clk_i      : clock, storage writes on the rising edge
//   reset_n_i  : asynchronous active-low reset, clears both entries to zero
//   w_v_i      : write enable for the entry selected by w_ptr_i
//   w_ptr_i    : write pointer (entry index)
//   w_data_i   : word written when w_v_i is high
//   r_ptr_i    : read pointer (entry index)
//   r_data_o   : combinational read of the entry at r_ptr_i
module bsg_dlatch_drain_mem #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               w_v_i,
    input  logic               w_ptr_i,
    input  logic [width_p-1:0] w_data_i,
    input  logic               r_ptr_i,
    output logic [width_p-1:0] r_data_o
);

    logic [width_p-1:0] entry0_r;
    logic [width_p-1:0] entry1_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            entry0_r <= '0;
            entry1_r <= '0;
        end else if (w_v_i) begin
            if (w_ptr_i) begin
                entry1_r <= w_data_i;
            end else begin
                entry0_r <= w_data_i;
            end
        end
    end

    assign r_data_o = r_ptr_i ? entry1_r : entry0_r;

endmodule

// File: rtl/bsg_dlatch_drain.sv
// rtl/bsg_dlatch_drain.sv - two-entry drain queue behind an upstream transparent latch bank
//
// Ports:
//   clk_i        : sole clock, all state updates on the rising edge
//   reset_n_i    : asynchronous active-low reset
//   latch_data_i : upstream latch bank output, stable at the rising edge
//   latch_v_i    : upstream word is new and must be captured
//   latch_en_o   : registered enable for the upstream latch bank
//   v_o          : data_o holds a valid word
//   data_o       : head-of-queue word
//   yumi_i       : consumer takes data_o this cycle (ignored when v_o=0)
//   count_o      : occupancy, 0..2
//   overrun_o    : sticky flag, a word arrived while latch_en_o was low
module bsg_dlatch_drain #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] latch_data_i,
    input  logic               latch_v_i,
    output logic               latch_en_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic [1:0]         count_o,
    output logic               overrun_o
);

    logic [1:0] count_r;
    logic [1:0] count_next;
    logic       wptr_r;
    logic       rptr_r;
    logic       en_r;
    logic       overrun_r;
    logic       enq;
    logic       deq;

    // Enqueue is gated by the registered enable, so a full queue can
    // never accept a word even if latch_v_i is held high.
    assign enq = latch_v_i & en_r;
    assign deq = yumi_i & v_o;

    always_comb begin
        count_next = count_r;
        if (enq && !deq) begin
            count_next = count_r + 2'd1;
        end else if (deq && !enq) begin
            count_next = count_r - 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r   <= 2'd0;
            wptr_r    <= 1'b0;
            rptr_r    <= 1'b0;
            en_r      <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            count_r <= count_next;
            if (enq) begin
                wptr_r <= ~wptr_r;
            end
            if (deq) begin
                rptr_r <= ~rptr_r;
            end
            // Enable is a flop so the latch bank sees a glitch-free gate;
            // it stays low during reset and first rises on the first edge after.
            en_r <= (count_next != 2'd2);
            if (latch_v_i && !en_r) begin
                overrun_r <= 1'b1;
            end
        end
    end

    bsg_dlatch_drain_mem #(
        .width_p(width_p)
    ) mem (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .w_v_i    (enq),
        .w_ptr_i  (wptr_r),
        .w_data_i (latch_data_i),
        .r_ptr_i  (rptr_r),
        .r_data_o (data_o)
    );

    assign v_o        = (count_r != 2'd0);
    assign count_o    = count_r;
    assign latch_en_o = en_r;
    assign overrun_o  = overrun_r;

endmodule

// File: tb/tb_bsg_dlatch_drain.sv
// tb/tb_bsg_dlatch_drain.sv - scoreboard bench for bsg_dlatch_drain
module tb_bsg_dlatch_drain;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic [W-1:0] latch_data_i;
    logic         latch_v_i;
    logic         latch_en_o;
    logic         v_o;
    logic [W-1:0] data_o;
    logic         yumi_i;
    logic [1:0]   count_o;
    logic         overrun_o;

    int tests = 0;
    int fails = 0;

    // Reference model: a plain FIFO of words plus the two flags.
    logic [W-1:0] exp_q[$];
    logic         exp_en;
    logic         exp_ovr;
    bit           done = 1'b0;

    bsg_dlatch_drain #(.width_p(W)) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .latch_data_i(latch_data_i),
        .latch_v_i   (latch_v_i),
        .latch_en_o  (latch_en_o),
        .v_o         (v_o),
        .data_o      (data_o),
        .yumi_i      (yumi_i),
        .count_o     (count_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares on the falling edge, advances the model on the rising edge.
    initial begin
        exp_en  = 1'b0;
        exp_ovr = 1'b0;
        while (!done) begin
            @(negedge clk_i);
            if (!reset_n_i) begin
                exp_q.delete();
                exp_en  = 1'b0;
                exp_ovr = 1'b0;
            end else begin
                check("count", {30'd0, count_o}, W'(exp_q.size()));
                check("v", {31'd0, v_o}, {31'd0, exp_q.size() != 0});
                check("latch_en", {31'd0, latch_en_o}, {31'd0, exp_en});
                check("overrun", {31'd0, overrun_o}, {31'd0, exp_ovr});
                if (exp_q.size() != 0) begin
                    check("data", data_o, exp_q[0]);
                end
            end
            @(posedge clk_i);
            if (!reset_n_i) begin
                exp_q.delete();
                exp_en  = 1'b0;
                exp_ovr = 1'b0;
            end else begin
                if (latch_v_i && !exp_en) begin
                    exp_ovr = 1'b1;
                end
                if (yumi_i && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                end
                if (latch_v_i && exp_en) begin
                    exp_q.push_back(latch_data_i);
                end
                exp_en = (exp_q.size() < 2);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_n_i    = 1'b0;
        latch_v_i    = 1'b0;
        yumi_i       = 1'b0;
        latch_data_i = '0;
        #2;
        check("reset_count", {30'd0, count_o}, 32'd0);
        check("reset_en", {31'd0, latch_en_o}, 32'd0);
        check("reset_data", data_o, 32'd0);
        #20;
        reset_n_i = 1'b1;
        step();
        check("rel_en", {31'd0, latch_en_o}, 32'd1);
        check("rel_v", {31'd0, v_o}, 32'd0);
        check("rel_count", {30'd0, count_o}, 32'd0);
        check("rel_data", data_o, 32'd0);

        // Single word through and out.
        latch_v_i = 1'b1; latch_data_i = 32'hDEADBEEF;
        step();
        latch_v_i = 1'b0;
        check("single_v", {31'd0, v_o}, 32'd1);
        check("single_data", data_o, 32'hDEADBEEF);
        check("single_count", {30'd0, count_o}, 32'd1);
        yumi_i = 1'b1;
        step();
        yumi_i = 1'b0;
        check("single_drain_v", {31'd0, v_o}, 32'd0);
        check("single_drain_count", {30'd0, count_o}, 32'd0);

        // Fill, then overrun with a third word.
        latch_v_i = 1'b1; latch_data_i = 32'h1;
        step();
        latch_data_i = 32'h2;
        step();
        latch_v_i = 1'b0;
        check("fill_count", {30'd0, count_o}, 32'd2);
        check("fill_en", {31'd0, latch_en_o}, 32'd0);
        latch_v_i = 1'b1; latch_data_i = 32'h3;
        step();
        latch_v_i = 1'b0;
        check("ovr_flag", {31'd0, overrun_o}, 32'd1);
        check("ovr_count", {30'd0, count_o}, 32'd2);
        check("ovr_head", data_o, 32'h1);
        yumi_i = 1'b1;
        step();
        check("drain_second", data_o, 32'h2);
        check("drain_en", {31'd0, latch_en_o}, 32'd1);
        step();
        yumi_i = 1'b0;
        check("drain_empty", {30'd0, count_o}, 32'd0);

        // Streaming through pointer wrap with occupancy held at one.
        latch_v_i = 1'b1; latch_data_i = 32'd0;
        step();
        yumi_i = 1'b1;
        for (int i = 1; i < 8; i++) begin
            latch_data_i = i;
            step();
            check("stream_count", {30'd0, count_o}, 32'd1);
            check("stream_data", data_o, i);
        end
        latch_v_i = 1'b0;
        step();
        yumi_i = 1'b0;
        check("stream_end", {30'd0, count_o}, 32'd0);

        // Randomized traffic, including yumi while empty.
        for (int i = 0; i < 400; i++) begin
            latch_v_i    = 1'($urandom_range(0, 1));
            yumi_i       = ($urandom_range(0, 3) != 0);
            latch_data_i = $urandom;
            step();
        end
        latch_v_i = 1'b0;
        yumi_i    = 1'b0;
        step();

        // Async reset mid-cycle while full.
        latch_v_i = 1'b1; latch_data_i = 32'hA5A5;
        step();
        latch_data_i = 32'h5A5A;
        step();
        latch_v_i = 1'b0;
        step();
        check("pre_rst_count", {30'd0, count_o}, 32'd2);
        #2;
        reset_n_i = 1'b0;
        #1;
        check("arst_count", {30'd0, count_o}, 32'd0);
        check("arst_v", {31'd0, v_o}, 32'd0);
        check("arst_en", {31'd0, latch_en_o}, 32'd0);
        check("arst_ovr", {31'd0, overrun_o}, 32'd0);
        check("arst_data", data_o, 32'd0);
        @(negedge clk_i);
        #1;
        reset_n_i = 1'b1;
        step();
        check("post_rst_en", {31'd0, latch_en_o}, 32'd1);
        check("post_rst_v", {31'd0, v_o}, 32'd0);
        step();
        done = 1'b1;
        #20;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bsg_dlatch_drain.md
BSG_DLATCH_DRAIN -- requirements
Module: bsg_dlatch_drain

Interface
REQ-001 The block SHALL have parameter width_p, default 32, giving the data width of the upstream latch bank and of the output.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port clk_i, input, 1 bit: the sole clock; all state updates on its rising edge.
REQ-004 Port reset_n_i, input, 1 bit: asynchronous active-low reset.
REQ-005 Port latch_data_i, input, width_p bits: output of the upstream transparent-high latch bank, stable at the rising edge of clk_i.
REQ-006 Port latch_v_i, input, 1 bit: the upstream word on latch_data_i is new and must be captured.
REQ-007 Port latch_en_o, output, 1 bit: enable for the upstream latch bank; 1 means a word presented this cycle will be accepted.
REQ-008 Port v_o, output, 1 bit: data_o holds a valid word.
REQ-009 Port data_o, output, width_p bits: head-of-queue word.
REQ-010 Port yumi_i, input, 1 bit: the consumer takes data_o this cycle; it is legal only when v_o=1.
REQ-011 Port count_o, output, 2 bits: current occupancy, 0..2.
REQ-012 Port overrun_o, output, 1 bit: sticky error flag.

Function
REQ-013 The block SHALL hold a 2-entry in-order queue with 1-bit write and read pointers and a 2-bit count register.
REQ-014 An enqueue SHALL occur at a rising edge iff latch_v_i=1 and latch_en_o=1; it writes latch_data_i at the write pointer, and the write pointer toggles.
REQ-015 A dequeue SHALL occur at a rising edge iff yumi_i=1 and v_o=1; the read pointer toggles.
REQ-016 count_o SHALL follow: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
REQ-017 v_o SHALL equal (count_o != 0), and data_o SHALL be the entry at the read pointer.
REQ-018 Latency: a word enqueued at edge N SHALL appear on data_o with v_o=1 after edge N when the queue was empty.
REQ-019 latch_en_o SHALL be a flop loaded each edge with (count_next < 2); it is driven only from a register and is glitch-free.
REQ-020 When full, an enqueue SHALL be impossible because latch_en_o=0; a simultaneous dequeue SHALL still proceed, and latch_en_o returns to 1 after that edge.
REQ-021 When count=1, a simultaneous enqueue and dequeue SHALL leave count at 1 and latch_en_o at 1, with the new word becoming the head.
REQ-022 latch_v_i=1 while latch_en_o=0 SHALL drop the word and set overrun_o=1 at that edge; overrun_o clears only on reset.
REQ-023 yumi_i=1 while v_o=0 SHALL be ignored, with no state change.
REQ-024 Pointers SHALL wrap 1->0 naturally; ordering SHALL be preserved across wrap.

Reset
REQ-025 reset_n_i=0 SHALL immediately force count_o=0, both pointers=0, v_o=0, latch_en_o=0, overrun_o=0, and both storage entries=0, so data_o=0.
REQ-026 latch_en_o SHALL first rise at the first rising edge after reset_n_i deasserts; no enqueue can occur on that edge.
REQ-027 Reset asserted mid-operation SHALL discard queued words with no output pulse.

Structure
REQ-028 No shared package is needed; width_p is the only parameter and no typedefs are exported.
REQ-029 The 2-entry storage with reset SHALL be a sub-module, bsg_dlatch_drain_mem (write enable, write pointer, read pointer).

Verification
REQ-030 Reset release: after 1 edge, latch_en_o=1, v_o=0, count_o=0, data_o=0.
REQ-031 Single word: enqueue 0xDEADBEEF -> next cycle v_o=1, data_o=0xDEADBEEF, count_o=1; assert yumi_i -> v_o=0, count_o=0.
REQ-032 Fill: enqueue 0x1 then 0x2 with no yumi -> count_o=2, latch_en_o=0; yumi_i -> data_o=0x2 and latch_en_o=1 after the edge.
REQ-033 Overrun: queue full, latch_v_i=1 with 0x3 -> overrun_o=1, count_o stays 2, and the drained order is 0x1, 0x2.
REQ-034 Streaming: latch_v_i and yumi_i held high for 8 cycles with words 0..7 -> count_o steady at 1, outputs 0..7 in order through pointer wrap.
REQ-035 Async reset: assert reset_n_i mid-cycle with count_o=2 -> outputs clear before the next edge, and overrun_o=0.
